lzrw1_job_sequencer: RTL and testbench

- Front-end controller for the LZRW1 compressor core.
- Accepts an uncompressed byte stream over a valid/ready handshake and maintains a 16-byte sliding lookahead window.
- Issues exactly one core_valid pulse per input byte, so byte k sits in window lane 0 on the k-th pulse.
- Clears the core at job start, flushes the window at end of job, then waits for the core's Done with a timeout and reports completion and error status.

---
 rtl/lzrw1_job_sequencer.sv | 173 +++++++++++++++++
 tb/tb_lzrw1_job_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzrw1_job_sequencer.sv
// Front-end job sequencer for the LZRW1 compressor core: feeds a 16-byte lookahead
// window one byte per core_valid pulse, flushes at end of job and waits for Done.
`timescale 1ns/1ps

module lzrw1_job_sequencer #(
  parameter int WINDOW     = 16,
  parameter int STRINGSIZE = 4096,
  parameter int TIMEOUT    = 8192
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  core_clear,
  output logic                  core_valid,
  output logic [WINDOW*8-1:0]   core_window,
  input  logic                  core_done,
  output logic                  busy,
  output logic                  job_done,
  output logic [1:0]            job_err,
  output logic [12:0]           byte_count
);

  localparam int FILLW  = $clog2(WINDOW + 1);
  localparam int PADW   = $clog2(WINDOW);
  localparam int TIMERW = $clog2(TIMEOUT);
  localparam int CNTW   = 13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_FLUSH,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [WINDOW*8-1:0]   window_q, window_d;
  logic [FILLW-1:0]      fill_q, fill_d;
  logic [CNTW-1:0]       count_q, count_d;
  logic [PADW-1:0]       pad_q, pad_d;
  logic [TIMERW-1:0]     timer_q, timer_d;
  logic [1:0]            err_q, err_d;
  logic                  core_valid_q, core_valid_d;
  logic [WINDOW*8-1:0]   core_window_q;
  logic                  core_clear_q;
  logic                  busy_q;
  logic                  job_done_q;
  logic                  in_ready_q;
  logic                  accept;
  logic                  shift;
  logic [7:0]            shift_byte;

  assign accept = (state_q == S_LOAD) && in_valid && in_ready_q;

  always_comb begin
    state_d      = state_q;
    window_d     = window_q;
    fill_d       = fill_q;
    count_d      = count_q;
    pad_d        = pad_q;
    timer_d      = timer_q;
    err_d        = err_q;
    shift        = 1'b0;
    shift_byte   = 8'h00;
    core_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        window_d = '0;
        fill_d   = '0;
        count_d  = '0;
        err_d    = 2'b00;
        state_d  = S_LOAD;
      end
      S_LOAD: begin
        if (accept) begin
          shift      = 1'b1;
          shift_byte = in_data;
          count_d    = count_q + CNTW'(1);
          if (in_last) begin
            state_d = S_FLUSH;
            pad_d   = PADW'(WINDOW - 1);
          end else if (count_q == CNTW'(STRINGSIZE - 1)) begin
            err_d[0] = 1'b1;
            state_d  = S_FLUSH;
            pad_d    = PADW'(WINDOW - 1);
          end
        end
      end
      S_FLUSH: begin
        // Zero padding pushes the tail bytes down to lane 0, one per cycle.
        shift = 1'b1;
        pad_d = pad_q - PADW'(1);
        if (pad_q == PADW'(1)) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + TIMERW'(1);
        if (core_done) begin
          state_d = S_FINISH;
        end else if (timer_q == TIMERW'(TIMEOUT - 1)) begin
          err_d[1] = 1'b1;
          state_d  = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (shift) begin
      window_d = {shift_byte, window_q[WINDOW*8-1:8]};
      if (fill_q != FILLW'(WINDOW)) fill_d = fill_q + FILLW'(1);
      core_valid_d = ((fill_q == FILLW'(WINDOW)) || (fill_q == FILLW'(WINDOW - 1)));
    end
  end

  // Status outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      window_q      <= '0;
      fill_q        <= '0;
      count_q       <= '0;
      pad_q         <= '0;
      timer_q       <= '0;
      err_q         <= 2'b00;
      core_valid_q  <= 1'b0;
      core_window_q <= '0;
      core_clear_q  <= 1'b0;
      busy_q        <= 1'b0;
      job_done_q    <= 1'b0;
      in_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      window_q     <= window_d;
      fill_q       <= fill_d;
      count_q      <= count_d;
      pad_q        <= pad_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      core_valid_q <= core_valid_d;
      if (core_valid_d) core_window_q <= window_d;
      core_clear_q <= (state_d == S_CLEAR);
      busy_q       <= (state_d != S_IDLE);
      job_done_q   <= (state_d == S_FINISH);
      in_ready_q   <= (state_d == S_LOAD) && (count_d < CNTW'(STRINGSIZE));
    end
  end

  assign in_ready    = in_ready_q;
  assign core_clear  = core_clear_q;
  assign core_valid  = core_valid_q;
  assign core_window = core_window_q;
  assign busy        = busy_q;
  assign job_done    = job_done_q;
  assign job_err     = err_q;
  assign byte_count  = count_q;

endmodule

// File: tb/tb_lzrw1_job_sequencer.sv
// Directed bench for lzrw1_job_sequencer: accepted bytes feed a queue that predicts
// every core_window pulse, plus per-job checks of counts, status and latencies.
`timescale 1ns/1ps

module tb_lzrw1_job_sequencer;

  localparam int WINDOW     = 16;
  localparam int STRINGSIZE = 4096;
  localparam int TIMEOUT    = 8192;

  logic                clock;
  logic                reset;
  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic [7:0]          in_data;
  logic                in_last;
  logic                core_clear;
  logic                core_valid;
  logic [WINDOW*8-1:0] core_window;
  logic                core_done;
  logic                busy;
  logic                job_done;
  logic [1:0]          job_err;
  logic [12:0]         byte_count;

  int vectors     = 0;
  int miscompares = 0;
  int pulseCount  = 0;
  int clearCount  = 0;
  int doneCount   = 0;
  int jobBytes    = 0;
  logic [7:0] expQ[$];

  lzrw1_job_sequencer #(
    .WINDOW(WINDOW),
    .STRINGSIZE(STRINGSIZE),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .core_clear(core_clear),
    .core_valid(core_valid),
    .core_window(core_window),
    .core_done(core_done),
    .busy(busy),
    .job_done(job_done),
    .job_err(job_err),
    .byte_count(byte_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Scoreboard: each window pulse must show the oldest pending bytes, zero padded.
  always @(negedge clock) begin
    if (core_clear) clearCount++;
    if (job_done) doneCount++;
    if (core_valid) begin
      logic [127:0] expWin;
      expWin = '0;
      for (int i = 0; i < WINDOW; i++)
        if (i < expQ.size()) expWin[8*i +: 8] = expQ[i];
      pulseCount++;
      checkOutput("core_window", core_window, expWin);
      if (expQ.size() > 0) void'(expQ.pop_front());
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic l);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      checkOutput("in_ready_wait", in_ready, 1);
    end else begin
      expQ.push_back(d);
      jobBytes++;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic startJob();
    pulseCount = 0;
    clearCount = 0;
    doneCount  = 0;
    jobBytes   = 0;
    expQ.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("clear_pulse", core_clear, 1);
    tick();
    checkOutput("load_ready", in_ready, 1);
    checkOutput("load_count", byte_count, 0);
    checkOutput("load_err", job_err, 0);
  endtask

  task automatic waitLastPulse(output int lat, output int firstLat);
    lat = 0;
    firstLat = -1;
    while (pulseCount < jobBytes && lat < 100) begin
      tick();
      lat++;
      if (pulseCount > 0 && firstLat < 0) firstLat = lat;
    end
    checkOutput("pulse_total", pulseCount, jobBytes);
  endtask

  task automatic finishJob(input int delay);
    for (int i = 0; i < delay; i++) tick();
    core_done = 1'b1;
    tick();
    checkOutput("job_done_pulse", job_done, 1);
    core_done = 1'b0;
    tick();
    checkOutput("job_done_clear", job_done, 0);
    checkOutput("idle_busy", busy, 0);
  endtask

  task automatic endJobChecks(input int bytes, input logic [1:0] err);
    checkOutput("byte_count", byte_count, bytes);
    checkOutput("job_err", job_err, err);
    checkOutput("pulses_vs_bytes", pulseCount, bytes);
    checkOutput("clear_count", clearCount, 1);
    checkOutput("done_count", doneCount, 1);
  endtask

  initial begin
    int lat;
    int firstLat;
    int acc;
    int stall;
    int n;

    reset     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    core_done = 1'b0;
    tick();
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", in_ready, 0);
    checkOutput("rst_valid", core_valid, 0);
    checkOutput("rst_window", core_window, 0);
    checkOutput("rst_err", job_err, 0);
    reset = 1'b1;
    tick();

    $display("[TB] normal 20-byte job");
    startJob();
    for (int b = 1; b <= 20; b++) begin
      if (b == 8) start = 1'b1;
      applyStimulus(8'(b), b == 20);
      start = 1'b0;
    end
    waitLastPulse(lat, firstLat);
    checkOutput("last_latency", lat, 15);
    finishJob(5);
    endJobChecks(20, 2'b00);

    $display("[TB] sub-window 3-byte job");
    startJob();
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b0);
    applyStimulus(8'hCC, 1'b1);
    waitLastPulse(lat, firstLat);
    checkOutput("sub_first_latency", firstLat, 13);
    checkOutput("sub_last_latency", lat, 15);
    finishJob(0);
    endJobChecks(3, 2'b00);

    $display("[TB] backpressure 40-byte job");
    startJob();
    for (int b = 1; b <= 40; b++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      applyStimulus(8'($urandom), b == 40);
    end
    waitLastPulse(lat, firstLat);
    finishJob(2);
    endJobChecks(40, 2'b00);

    $display("[TB] overflow job");
    startJob();
    acc = 0;
    stall = 0;
    while (acc < 4100 && stall < 40) begin
      in_valid = 1'b1;
      in_data  = 8'(acc * 7 + 3);
      in_last  = 1'b0;
      if (in_ready === 1'b1) begin
        expQ.push_back(in_data);
        jobBytes++;
        acc++;
        stall = 0;
      end else begin
        stall++;
      end
      tick();
    end
    in_valid = 1'b0;
    checkOutput("ovf_accepts", acc, STRINGSIZE);
    checkOutput("ovf_ready_low", in_ready, 0);
    core_done = 1'b1;
    n = 0;
    while (job_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    core_done = 1'b0;
    checkOutput("ovf_job_done", job_done, 1);
    tick();
    endJobChecks(STRINGSIZE, 2'b01);

    $display("[TB] timeout job");
    startJob();
    for (int b = 0; b < 5; b++) applyStimulus(8'(8'h40 + b), b == 4);
    waitLastPulse(lat, firstLat);
    n = 0;
    while (job_done !== 1'b1 && n < TIMEOUT + 100) begin
      tick();
      n++;
    end
    checkOutput("timeout_cycles", n, TIMEOUT);
    tick();
    endJobChecks(5, 2'b10);

    $display("[TB] restart clears error, then async reset mid-load");
    startJob();
    for (int b = 0; b < 10; b++) applyStimulus(8'(8'h80 + b), 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_ready", in_ready, 0);
    checkOutput("arst_count", byte_count, 0);
    checkOutput("arst_outputs", {core_valid, core_clear, job_done, job_err}, 0);
    repeat (3) tick();
    checkOutput("arst_no_done", doneCount, 0);
    reset = 1'b1;
    tick();

    $display("[TB] clean job after reset");
    startJob();
    for (int b = 0; b < 18; b++) applyStimulus(8'(8'hF0 - b), b == 17);
    waitLastPulse(lat, firstLat);
    checkOutput("post_rst_latency", lat, 15);
    finishJob(1);
    endJobChecks(18, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
